// File: rtl/axis_frame_len_stats_pkg.sv
// Shared types and constants for the frame-length statistics block.
// Used by axis_frame_len_stats and axis_stats_sat_cnt.
package axis_frame_len_stats_pkg;

    localparam int LEN_WIDTH_DEF = 16;
    localparam int CNT_WIDTH_DEF = 32;
    localparam int SUM_WIDTH_DEF = 48;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    // All-ones pattern of the requested width (at most 64 bits).
    // Callers cast the result down to their own width.
    function automatic logic [63:0] ones(input int width);
        if (width >= 64) begin
            return '1;
        end
        return (64'd1 << width) - 64'd1;
    endfunction

endpackage

// File: rtl/axis_stats_sat_cnt.sv
// Saturating accumulator: adds add_val every cycle and sticks at all-ones.
// count_next includes this cycle's add so a snapshot can capture it before clear.
module axis_stats_sat_cnt
    import axis_frame_len_stats_pkg::*;
#(
    parameter int WIDTH = CNT_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic [WIDTH-1:0] add_val,
    output logic [WIDTH-1:0] count_next
);

    logic [WIDTH-1:0] count_reg;
    logic [WIDTH:0]   sum_wide;

    assign sum_wide   = {1'b0, count_reg} + {1'b0, add_val};
    assign count_next = sum_wide[WIDTH] ? '1 : sum_wide[WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (!rst) begin
            count_reg <= '0;
        end else if (clear) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

endmodule

// File: rtl/axis_frame_len_stats.sv
// Per-window frame length statistics with a valid/ready snapshot interface.
// Optional sticky error flag enabled by defining AXIS_FRAME_LEN_STATS_ERR_EN.
module axis_frame_len_stats
    import axis_frame_len_stats_pkg::*;
#(
    parameter int LEN_WIDTH = LEN_WIDTH_DEF,
    parameter int CNT_WIDTH = CNT_WIDTH_DEF,
    parameter int SUM_WIDTH = SUM_WIDTH_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [LEN_WIDTH-1:0] frame_len,
    input  logic                 frame_len_valid,
    input  logic [LEN_WIDTH-1:0] cfg_min_len,
    input  logic [LEN_WIDTH-1:0] cfg_max_len,
    input  logic                 snapshot_req,
    output logic                 stat_valid,
    input  logic                 stat_ready,
    output logic [CNT_WIDTH-1:0] stat_frames,
    output logic [SUM_WIDTH-1:0] stat_bytes,
    output logic [LEN_WIDTH-1:0] stat_min,
    output logic [LEN_WIDTH-1:0] stat_max,
    output logic [CNT_WIDTH-1:0] stat_runt,
    output logic [CNT_WIDTH-1:0] stat_oversize
`ifdef AXIS_FRAME_LEN_STATS_ERR_EN
    ,
    output logic                 err_flag,
    input  logic                 err_clear
`endif
);

    localparam logic [LEN_WIDTH-1:0] MIN_INIT = LEN_WIDTH'(ones(LEN_WIDTH));

    state_t state_reg, state_next;
    logic   pending_reg, pending_next;
    logic   take_snap;

    logic runt_hit, over_hit;
    assign runt_hit = frame_len_valid && (frame_len < cfg_min_len);
    assign over_hit = frame_len_valid && (frame_len > cfg_max_len);

    // Counters: index 0 frames, 1 runts, 2 oversize.
    logic [2:0]           inc_vec;
    logic [CNT_WIDTH-1:0] cnt_next [3];
    assign inc_vec = {over_hit, runt_hit, frame_len_valid};

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_cnt
            axis_stats_sat_cnt #(.WIDTH(CNT_WIDTH)) u_cnt (
                .clk        (clk),
                .rst        (rst),
                .clear      (take_snap),
                .add_val    (CNT_WIDTH'(inc_vec[gi])),
                .count_next (cnt_next[gi])
            );
        end
    endgenerate

    // A length wider than the accumulator is clipped to all-ones rather than truncated.
    logic [SUM_WIDTH-1:0] len_ext;
    logic [SUM_WIDTH-1:0] bytes_next;
    generate
        if (SUM_WIDTH >= LEN_WIDTH) begin : g_len_zext
            assign len_ext = SUM_WIDTH'(frame_len);
        end else begin : g_len_clip
            assign len_ext = (|frame_len[LEN_WIDTH-1:SUM_WIDTH]) ? '1 : frame_len[SUM_WIDTH-1:0];
        end
    endgenerate

    axis_stats_sat_cnt #(.WIDTH(SUM_WIDTH)) u_bytes (
        .clk        (clk),
        .rst        (rst),
        .clear      (take_snap),
        .add_val    (frame_len_valid ? len_ext : '0),
        .count_next (bytes_next)
    );

    logic [LEN_WIDTH-1:0] min_reg, max_reg, min_next, max_next;
    assign min_next = (frame_len_valid && (frame_len < min_reg)) ? frame_len : min_reg;
    assign max_next = (frame_len_valid && (frame_len > max_reg)) ? frame_len : max_reg;

    always_ff @(posedge clk) begin
        if (!rst || take_snap) begin
            min_reg <= MIN_INIT;
            max_reg <= '0;
        end else begin
            min_reg <= min_next;
            max_reg <= max_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg   <= ST_IDLE;
            pending_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            pending_reg <= pending_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        pending_next = pending_reg;
        take_snap    = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (snapshot_req) begin
                    take_snap  = 1'b1;
                    state_next = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (stat_ready) begin
                    // Handshake: a queued or coincident request reloads immediately.
                    pending_next = 1'b0;
                    if (pending_reg || snapshot_req) begin
                        take_snap = 1'b1;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end else if (snapshot_req) begin
                    pending_next = 1'b1;
                end
            end
            default: begin
                state_next   = ST_IDLE;
                pending_next = 1'b0;
            end
        endcase
    end

    assign stat_valid = (state_reg == ST_HOLD);

    logic [CNT_WIDTH-1:0] stat_frames_reg, stat_runt_reg, stat_oversize_reg;
    logic [SUM_WIDTH-1:0] stat_bytes_reg;
    logic [LEN_WIDTH-1:0] stat_min_reg, stat_max_reg;
    logic                 window_empty;

    // Frame counter saturates rather than wrapping, so zero reliably means empty.
    assign window_empty = (cnt_next[0] == '0);

    always_ff @(posedge clk) begin
        if (!rst) begin
            stat_frames_reg   <= '0;
            stat_bytes_reg    <= '0;
            stat_min_reg      <= '0;
            stat_max_reg      <= '0;
            stat_runt_reg     <= '0;
            stat_oversize_reg <= '0;
        end else if (take_snap) begin
            stat_frames_reg   <= cnt_next[0];
            stat_bytes_reg    <= bytes_next;
            stat_min_reg      <= window_empty ? '0 : min_next;
            stat_max_reg      <= window_empty ? '0 : max_next;
            stat_runt_reg     <= cnt_next[1];
            stat_oversize_reg <= cnt_next[2];
        end
    end

    assign stat_frames   = stat_frames_reg;
    assign stat_bytes    = stat_bytes_reg;
    assign stat_min      = stat_min_reg;
    assign stat_max      = stat_max_reg;
    assign stat_runt     = stat_runt_reg;
    assign stat_oversize = stat_oversize_reg;

`ifdef AXIS_FRAME_LEN_STATS_ERR_EN
    logic err_flag_reg;

    always_ff @(posedge clk) begin
        if (!rst) begin
            err_flag_reg <= 1'b0;
        end else if (runt_hit || over_hit) begin
            err_flag_reg <= 1'b1;
        end else if (err_clear) begin
            err_flag_reg <= 1'b0;
        end
    end

    assign err_flag = err_flag_reg;
`endif

endmodule

// File: tb/tb_axis_frame_len_stats.sv
// Randomized + directed bench for axis_frame_len_stats against a window-level model.
// Err-flag checks are active when AXIS_FRAME_LEN_STATS_ERR_EN is defined.
module tb_axis_frame_len_stats;

    localparam longint LMAX = 64'hFFFF;
    localparam longint CMAX = 64'hFFFF_FFFF;
    localparam longint SMAX = 64'hFFFF_FFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] frame_len = '0;
    logic        frame_len_valid = 1'b0;
    logic [15:0] cfg_min_len = 16'd64;
    logic [15:0] cfg_max_len = 16'd1518;
    logic        snapshot_req = 1'b0;
    logic        stat_ready = 1'b1;
    logic        stat_valid;
    logic [31:0] stat_frames, stat_runt, stat_oversize;
    logic [47:0] stat_bytes;
    logic [15:0] stat_min, stat_max;
    logic        err_flag;
    logic        err_clear = 1'b0;

    // Small-width instance used for the saturation scenario.
    logic [15:0] s_len = '0;
    logic        s_valid = 1'b0;
    logic        s_req = 1'b0;
    logic        s_ready = 1'b1;
    logic        s_stat_valid;
    logic [3:0]  s_frames, s_runt, s_over;
    logic [7:0]  s_bytes;
    logic [15:0] s_min, s_max;
    logic        s_err;

    always #5 clk = ~clk;

    axis_frame_len_stats u_dut (
        .clk             (clk),
        .rst             (rst),
        .frame_len       (frame_len),
        .frame_len_valid (frame_len_valid),
        .cfg_min_len     (cfg_min_len),
        .cfg_max_len     (cfg_max_len),
        .snapshot_req    (snapshot_req),
        .stat_valid      (stat_valid),
        .stat_ready      (stat_ready),
        .stat_frames     (stat_frames),
        .stat_bytes      (stat_bytes),
        .stat_min        (stat_min),
        .stat_max        (stat_max),
        .stat_runt       (stat_runt),
        .stat_oversize   (stat_oversize)
`ifdef AXIS_FRAME_LEN_STATS_ERR_EN
        ,
        .err_flag        (err_flag),
        .err_clear       (err_clear)
`endif
    );

    axis_frame_len_stats #(.LEN_WIDTH(16), .CNT_WIDTH(4), .SUM_WIDTH(8)) u_sat (
        .clk             (clk),
        .rst             (rst),
        .frame_len       (s_len),
        .frame_len_valid (s_valid),
        .cfg_min_len     (cfg_min_len),
        .cfg_max_len     (cfg_max_len),
        .snapshot_req    (s_req),
        .stat_valid      (s_stat_valid),
        .stat_ready      (s_ready),
        .stat_frames     (s_frames),
        .stat_bytes      (s_bytes),
        .stat_min        (s_min),
        .stat_max        (s_max),
        .stat_runt       (s_runt),
        .stat_oversize   (s_over)
`ifdef AXIS_FRAME_LEN_STATS_ERR_EN
        ,
        .err_flag        (s_err),
        .err_clear       (1'b0)
`endif
    );

`ifndef AXIS_FRAME_LEN_STATS_ERR_EN
    assign err_flag = 1'b0;
    assign s_err    = 1'b0;
`endif

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Window-level reference: live window, held snapshot, queued request, err flag.
    typedef struct {
        longint frames, bytes, mn, mx, runt, over;
        bit     held, pend;
        longint s_frames, s_bytes, s_min, s_max, s_runt, s_over;
        bit     err;
    } model_t;

    function automatic longint sat(input longint x, input longint lim);
        return (x > lim) ? lim : x;
    endfunction

    function automatic model_t model_reset();
        model_t n;
        n.frames = 0; n.bytes = 0; n.mn = LMAX; n.mx = 0; n.runt = 0; n.over = 0;
        n.held = 0; n.pend = 0;
        n.s_frames = 0; n.s_bytes = 0; n.s_min = 0; n.s_max = 0; n.s_runt = 0; n.s_over = 0;
        n.err = 0;
        return n;
    endfunction

    function automatic model_t model_step(input model_t m, input bit v, input longint len,
                                          input longint cmin, input longint cmax,
                                          input bit req, input bit rdy, input bit eclr);
        model_t n = m;
        bit snap;
        bit hit = 0;
        if (v) begin
            n.frames = sat(n.frames + 1, CMAX);
            n.bytes  = sat(n.bytes + len, SMAX);
            if (len < n.mn) n.mn = len;
            if (len > n.mx) n.mx = len;
            if (len < cmin) begin n.runt = sat(n.runt + 1, CMAX); hit = 1; end
            if (len > cmax) begin n.over = sat(n.over + 1, CMAX); hit = 1; end
        end
        snap = m.held ? (rdy && (m.pend || req)) : req;
        if (m.held) begin
            if (rdy) begin
                n.pend = 0;
                n.held = snap;
            end else if (req) begin
                n.pend = 1;
            end
        end else begin
            n.held = req;
        end
        if (snap) begin
            n.s_frames = n.frames; n.s_bytes = n.bytes;
            n.s_min = (n.frames == 0) ? 0 : n.mn;
            n.s_max = (n.frames == 0) ? 0 : n.mx;
            n.s_runt = n.runt; n.s_over = n.over;
            n.frames = 0; n.bytes = 0; n.mn = LMAX; n.mx = 0; n.runt = 0; n.over = 0;
        end
        n.err = hit ? 1'b1 : (eclr ? 1'b0 : m.err);
        return n;
    endfunction

    model_t m;
    bit     cmp_en = 1'b0;

    always @(posedge clk) begin
        if (!rst) begin
            m <= model_reset();
        end else begin
            m <= model_step(m, frame_len_valid, longint'(frame_len), longint'(cfg_min_len),
                            longint'(cfg_max_len), snapshot_req, stat_ready, err_clear);
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("valid",    longint'(stat_valid),    longint'(m.held));
            check("frames",   longint'(stat_frames),   m.s_frames);
            check("bytes",    longint'(stat_bytes),    m.s_bytes);
            check("min",      longint'(stat_min),      m.s_min);
            check("max",      longint'(stat_max),      m.s_max);
            check("runt",     longint'(stat_runt),     m.s_runt);
            check("oversize", longint'(stat_oversize), m.s_over);
`ifdef AXIS_FRAME_LEN_STATS_ERR_EN
            check("err_flag", longint'(err_flag),      longint'(m.err));
`endif
        end
    end

    task automatic cyc(input bit v, input int len, input bit req);
        frame_len_valid = v;
        frame_len       = 16'(len);
        snapshot_req    = req;
        @(posedge clk);
        #1;
        frame_len_valid = 1'b0;
        snapshot_req    = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid",  longint'(stat_valid),  0);
        check("rst_frames", longint'(stat_frames), 0);
        check("rst_bytes",  longint'(stat_bytes),  0);
        check("rst_err",    longint'(err_flag),    0);
        rst    = 1'b1;
        cmp_en = 1'b1;

        // Basic window: 64 / 1518 / 60, ready tied high.
        cfg_min_len = 16'd64; cfg_max_len = 16'd1518; stat_ready = 1'b1;
        cyc(1, 64, 0); cyc(1, 1518, 0); cyc(1, 60, 0);
        cyc(0, 0, 1);
        check("s1_valid",  longint'(stat_valid),    1);
        check("s1_frames", longint'(stat_frames),   3);
        check("s1_bytes",  longint'(stat_bytes),    1642);
        check("s1_min",    longint'(stat_min),      60);
        check("s1_max",    longint'(stat_max),      1518);
        check("s1_runt",   longint'(stat_runt),     1);
        check("s1_over",   longint'(stat_oversize), 0);
        cyc(0, 0, 0);
        check("s1_pulse",  longint'(stat_valid),    0);

        // Frame coincident with the request lands in the closing window.
        cyc(1, 100, 1);
        check("s2_frames", longint'(stat_frames), 1);
        check("s2_bytes",  longint'(stat_bytes),  100);
        cyc(0, 0, 0);
        cyc(0, 0, 1);
        check("s2_empty_frames", longint'(stat_frames), 0);
        check("s2_empty_min",    longint'(stat_min),    0);
        check("s2_empty_max",    longint'(stat_max),    0);
        cyc(0, 0, 0);

        // Held snapshot with queued requests.
        stat_ready = 1'b0;
        cyc(0, 0, 1);
        cyc(1, 200, 1); cyc(1, 200, 0); cyc(1, 200, 1);
        check("s3_hold_valid",  longint'(stat_valid),  1);
        check("s3_hold_frames", longint'(stat_frames), 0);
        stat_ready = 1'b1;
        cyc(0, 0, 0);
        check("s3_re_valid",  longint'(stat_valid),  1);
        check("s3_re_frames", longint'(stat_frames), 3);
        check("s3_re_bytes",  longint'(stat_bytes),  600);
        cyc(0, 0, 0);
        check("s3_fall", longint'(stat_valid), 0);

        // Reset while holding with a pending request.
        stat_ready = 1'b0;
        cyc(1, 500, 1);
        cyc(0, 0, 1);
        rst = 1'b0;
        cyc(0, 0, 0);
        check("s5_valid",  longint'(stat_valid),  0);
        check("s5_frames", longint'(stat_frames), 0);
        check("s5_bytes",  longint'(stat_bytes),  0);
        check("s5_max",    longint'(stat_max),    0);
        rst = 1'b1; stat_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 0);
            check("s5_no_spurious", longint'(stat_valid), 0);
        end

        // Saturation on the narrow instance.
        cfg_min_len = 16'd64; cfg_max_len = 16'd1518;
        s_len = 16'd20; s_valid = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        s_valid = 1'b0; s_req = 1'b1;
        @(posedge clk);
        #1;
        s_req = 1'b0;
        check("sat_valid",  longint'(s_stat_valid), 1);
        check("sat_frames", longint'(s_frames),     15);
        check("sat_bytes",  longint'(s_bytes),      255);
        check("sat_runt",   longint'(s_runt),       15);
        check("sat_min",    longint'(s_min),        20);

`ifdef AXIS_FRAME_LEN_STATS_ERR_EN
        cfg_min_len = 16'd0; cfg_max_len = 16'd1518;
        err_clear = 1'b1; cyc(0, 0, 0); err_clear = 1'b0;
        check("err_idle", longint'(err_flag), 0);
        cyc(1, 2000, 0);
        check("err_set", longint'(err_flag), 1);
        err_clear = 1'b1; cyc(1, 2000, 0);
        check("err_set_wins", longint'(err_flag), 1);
        cyc(0, 0, 0); err_clear = 1'b0;
        check("err_cleared", longint'(err_flag), 0);
`endif

        // Randomized traffic, checked every cycle by the compare process.
        for (int i = 0; i < 3000; i++) begin
            int lenv;
            if ($urandom_range(0, 49) == 0) begin
                cfg_min_len = 16'($urandom_range(0, 1600));
                cfg_max_len = 16'($urandom_range(0, 2000));
            end
            stat_ready = 1'($urandom_range(0, 1));
            err_clear  = ($urandom_range(0, 7) == 0);
            rst        = ($urandom_range(0, 399) != 0);
            case ($urandom_range(0, 9))
                0:       lenv = 0;
                1:       lenv = 65535;
                default: lenv = int'($urandom_range(0, 2500));
            endcase
            cyc($urandom_range(0, 2) != 0, lenv, $urandom_range(0, 9) == 0);
        end
        rst = 1'b1; err_clear = 1'b0; stat_ready = 1'b1;
        repeat (3) cyc(0, 0, 0);
        @(negedge clk);
        cmp_en = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
